// File: rtl/zilla_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : zilla_pkg
//  Description : Shared definitions for the zilla adder arbiter slice.
//                Adder width, response-slot state encoding and a reusable
//                round-robin pick function for fabric arbiters of up to
//                eight requesters.
//  Revision    : 1.0 - initial release
// ============================================================================
package zilla_pkg;

    localparam int ADDER_W  = 8;
    localparam int RR_MAX   = 8;   // widest arbiter rr_pick can serve
    localparam int RR_IDX_W = 3;   // clog2(RR_MAX)

    // Response slot: EMPTY means rsp_valid=0, FULL means rsp_valid=1.
    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // Returns the first set bit of valid scanning ptr, ptr+1, ... wrapping
    // at num. Bits of valid at or above num are ignored. ptr must be < num.
    function automatic rr_pick_t rr_pick(
        input logic [RR_MAX-1:0]   valid,
        input logic [RR_IDX_W-1:0] ptr,
        input logic [RR_IDX_W:0]   num
    );
        rr_pick_t            r;
        logic [RR_IDX_W:0]   k;
        r = '0;
        for (int i = 0; i < RR_MAX; i++) begin
            // ptr < num and i < num, so one conditional subtract wraps.
            k = {1'b0, ptr} + (RR_IDX_W+1)'(i);
            if (k >= num) begin
                k = k - num;
            end
            if (((RR_IDX_W+1)'(i) < num) && !r.found && valid[k[RR_IDX_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = k[RR_IDX_W-1:0];
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla_adder_8bit.sv
`default_nettype none
// ============================================================================
//  Module      : cla_adder_8bit
//  Description : 8-bit carry-lookahead adder built from two 4-bit lookahead
//                groups. No carry-in, no carry-out: sum = (ain + bin) mod 256.
//  Ports       : ain [7:0] in, bin [7:0] in, sum [7:0] out
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_adder_8bit (
    input  logic [7:0] ain,
    input  logic [7:0] bin,
    output logic [7:0] sum
);

    logic [7:0] w_g;
    logic [7:0] w_p;
    logic [7:0] w_c;

    assign w_g = ain & bin;
    assign w_p = ain ^ bin;

    assign w_c[0] = 1'b0;

    // Group generate of the low nibble is the carry into the high nibble.
    assign w_c[4] = w_g[3]
                  | (w_p[3] & w_g[2])
                  | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

    for (genvar b = 0; b < 2; b++) begin : g_blk
        localparam int c_L = 4 * b;
        assign w_c[c_L+1] = w_g[c_L]
                          | (w_p[c_L] & w_c[c_L]);
        assign w_c[c_L+2] = w_g[c_L+1]
                          | (w_p[c_L+1] & w_g[c_L])
                          | (w_p[c_L+1] & w_p[c_L] & w_c[c_L]);
        assign w_c[c_L+3] = w_g[c_L+2]
                          | (w_p[c_L+2] & w_g[c_L+1])
                          | (w_p[c_L+2] & w_p[c_L+1] & w_g[c_L])
                          | (w_p[c_L+2] & w_p[c_L+1] & w_p[c_L] & w_c[c_L]);
    end

    assign sum = w_p ^ w_c;

endmodule
`default_nettype wire

// File: rtl/zilla_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : zilla_rr_arbiter
//  Description : Round-robin arbiter: priority pointer register plus one-hot
//                grant. The pointer moves to winner+1 (wrapping at NUM_REQ-1)
//                on every grant and holds otherwise.
//  Ports       : clk, rst        clock, synchronous active-high reset
//                req_valid  in   per-requester request
//                can_accept in   downstream slot can take a result this cycle
//                grant      out  one-hot grant, all zero when nothing granted
//                grant_id   out  index of the winner (valid when grant_any)
//                grant_any  out  a grant is issued this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module zilla_rr_arbiter
    import zilla_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               can_accept,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_any
);

    logic [ID_W-1:0]     r_ptr;
    logic [RR_MAX-1:0]   w_valid_ext;
    logic [RR_IDX_W-1:0] w_ptr_ext;
    rr_pick_t            w_pick;

    always_comb begin
        w_valid_ext                = '0;
        w_valid_ext[NUM_REQ-1:0]   = req_valid;
        w_ptr_ext                  = '0;
        w_ptr_ext[ID_W-1:0]        = r_ptr;
    end

    assign w_pick    = rr_pick(w_valid_ext, w_ptr_ext, (RR_IDX_W+1)'(NUM_REQ));
    assign grant_id  = w_pick.idx[ID_W-1:0];
    assign grant_any = w_pick.found & can_accept;

    always_comb begin
        grant = '0;
        if (grant_any) begin
            grant[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (grant_any) begin
            // Explicit wrap so non-power-of-2 NUM_REQ never reaches an
            // index that has no port.
            if (grant_id == ID_W'(NUM_REQ - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= grant_id + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/zilla_adder_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : zilla_adder_arbiter
//  Description : Shares one 8-bit carry-lookahead adder between NUM_REQ
//                requesters. Round-robin valid/ready arbitration feeds a
//                single registered response slot tagged with requester ID
//                and a locally derived carry-out.
//  Ports       : clk, rst        clock, synchronous active-high reset
//                req_valid  in   [NUM_REQ]    per-requester request
//                req_ain    in   [NUM_REQ*8]  operand A, requester i at [8i+:8]
//                req_bin    in   [NUM_REQ*8]  operand B, same packing
//                req_ready  out  [NUM_REQ]    one-hot grant
//                rsp_valid  out               response slot holds a result
//                rsp_ready  in                consumer takes the response
//                rsp_sum    out  [8]          (A+B) mod 256
//                rsp_cout   out               carry out of bit 7
//                rsp_id     out  [ID_W]       requester that produced it
//  Revision    : 1.0 - initial release
// ============================================================================
module zilla_adder_arbiter
    import zilla_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*ADDER_W-1:0] req_ain,
    input  logic [NUM_REQ*ADDER_W-1:0] req_bin,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ADDER_W-1:0]         rsp_sum,
    output logic                       rsp_cout,
    output logic [ID_W-1:0]            rsp_id
);

    slot_state_t         r_state;
    logic [ADDER_W-1:0]  r_sum;
    logic                r_cout;
    logic [ID_W-1:0]     r_id;

    logic                w_can_accept;
    logic [ID_W-1:0]     w_grant_id;
    logic                w_grant_any;
    logic [ADDER_W-1:0]  w_a;
    logic [ADDER_W-1:0]  w_b;
    logic [ADDER_W-1:0]  w_sum;
    logic                w_cout;

    // Slot frees up either because it is empty or because the consumer
    // drains it this very cycle (pass-through). Reset blocks all grants.
    assign w_can_accept = ~rst & ((r_state == EMPTY) | rsp_ready);

    zilla_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .can_accept (w_can_accept),
        .grant      (req_ready),
        .grant_id   (w_grant_id),
        .grant_any  (w_grant_any)
    );

    assign w_a = req_ain[w_grant_id*ADDER_W +: ADDER_W];
    assign w_b = req_bin[w_grant_id*ADDER_W +: ADDER_W];

    cla_adder_8bit u_adder (
        .ain (w_a),
        .bin (w_b),
        .sum (w_sum)
    );

    // The adder has no carry-out; recover it from the top operand bits and
    // the top sum bit (a carry into bit 7 flips s7 relative to a7^b7).
    assign w_cout = (w_a[ADDER_W-1] & w_b[ADDER_W-1])
                  | ((w_a[ADDER_W-1] | w_b[ADDER_W-1]) & ~w_sum[ADDER_W-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_id    <= '0;
        end else if (w_grant_any) begin
            r_state <= FULL;
            r_sum   <= w_sum;
            r_cout  <= w_cout;
            r_id    <= w_grant_id;
        end else if (rsp_ready) begin
            // Drained with nothing new: payload holds its last value.
            r_state <= EMPTY;
        end
    end

    assign rsp_valid = (r_state == FULL);
    assign rsp_sum   = r_sum;
    assign rsp_cout  = r_cout;
    assign rsp_id    = r_id;

endmodule
`default_nettype wire

// File: tb/tb_zilla_adder_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_zilla_adder_arbiter
//  Description : Self-checking bench for zilla_adder_arbiter (NUM_REQ=4).
//                A negedge monitor keeps its own pointer/slot model, checks
//                every grant, pushes the expected response on each accept
//                and pops/compares it when the response is consumed.
//                Scenario tasks add targeted inline checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_zilla_adder_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                   clk;
    logic                   rst;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ*8-1:0]   req_ain;
    logic [NUM_REQ*8-1:0]   req_bin;
    logic [NUM_REQ-1:0]     req_ready;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [7:0]             rsp_sum;
    logic                   rsp_cout;
    logic [ID_W-1:0]        rsp_id;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [7:0]      sum;
        logic            cout;
    } exp_t;

    exp_t m_q[$];
    int   m_ptr      = 0;
    bit   m_prev_rst = 0;

    zilla_adder_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ain   (req_ain),
        .req_bin   (req_bin),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin : mon
        logic [NUM_REQ-1:0] exp_ready;
        logic [8:0]         t;
        logic [7:0]         a;
        logic [7:0]         b;
        bit                 full;
        bit                 can;
        bit                 found;
        int                 win;
        int                 idx;
        exp_t               e;

        if (rst) begin
            vectors++;
            if (req_ready !== '0) begin
                miscompares++;
                $display("FAIL mon_rst_ready: req_ready=%b expected 0000", req_ready);
            end
            if (m_prev_rst) begin
                vectors++;
                if (rsp_valid !== 1'b0 || rsp_sum !== 8'h00 || rsp_cout !== 1'b0 || rsp_id !== '0) begin
                    miscompares++;
                    $display("FAIL mon_rst_outputs: valid=%b sum=%h cout=%b id=%0d expected 0/00/0/0",
                             rsp_valid, rsp_sum, rsp_cout, rsp_id);
                end
            end
            m_q.delete();
            m_ptr      = 0;
            m_prev_rst = 1;
        end else begin
            m_prev_rst = 0;
            full = (m_q.size() > 0);
            vectors++;
            if (rsp_valid !== full) begin
                miscompares++;
                $display("FAIL mon_rsp_valid: got %b expected %b", rsp_valid, full);
            end
            if (full) begin
                vectors++;
                if (rsp_id !== m_q[0].id || rsp_sum !== m_q[0].sum || rsp_cout !== m_q[0].cout) begin
                    miscompares++;
                    $display("FAIL mon_rsp_data: got id=%0d sum=%h cout=%b expected id=%0d sum=%h cout=%b",
                             rsp_id, rsp_sum, rsp_cout, m_q[0].id, m_q[0].sum, m_q[0].cout);
                end
            end

            can   = !full || (rsp_ready === 1'b1);
            found = 0;
            win   = 0;
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (m_ptr + k) % NUM_REQ;
                if (!found && req_valid[idx]) begin
                    found = 1;
                    win   = idx;
                end
            end
            exp_ready = '0;
            if (can && found) exp_ready[win] = 1'b1;
            vectors++;
            if (req_ready !== exp_ready) begin
                miscompares++;
                $display("FAIL mon_grant: req_ready=%b expected %b", req_ready, exp_ready);
            end

            if (full && rsp_ready === 1'b1) void'(m_q.pop_front());
            if (can && found) begin
                a      = req_ain[win*8 +: 8];
                b      = req_bin[win*8 +: 8];
                t      = {1'b0, a} + {1'b0, b};
                e.id   = ID_W'(win);
                e.sum  = t[7:0];
                e.cout = t[8];
                m_q.push_back(e);
                m_ptr = (win + 1) % NUM_REQ;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] a, input logic [7:0] b);
        req_valid[i]       = v;
        req_ain[i*8 +: 8]  = a;
        req_bin[i*8 +: 8]  = b;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst       = 1'b1;
        rsp_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 8'(i), 8'(i));
        sample();
        vectors++;
        if (req_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ready: req_ready=%b expected 0000", req_ready);
        end
        tick();
        sample();
        vectors++;
        if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || rsp_sum !== 8'h00 || rsp_cout !== 1'b0 || rsp_id !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_state: ready=%b valid=%b sum=%h cout=%b id=%0d expected 0000/0/00/0/0",
                     req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id);
        end
        tick();
        rst       = 1'b0;
        rsp_ready = 1'b1;
        sample();
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_first_grant: req_ready=%b expected 0001", req_ready);
        end
        tick();
        req_valid = '0;
        sample();
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_first_rsp: valid=%b id=%0d expected 1/0", rsp_valid, rsp_id);
        end
    endtask

    task automatic test_single_carry();
        tick();
        set_req(2, 1'b1, 8'hF0, 8'h25);
        sample();
        vectors++;
        if (req_ready !== 4'b0100) begin
            miscompares++;
            $display("FAIL single_grant: req_ready=%b expected 0100", req_ready);
        end
        tick();
        set_req(2, 1'b1, 8'h12, 8'h34);
        sample();
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 8'h15 || rsp_cout !== 1'b1 || rsp_id !== 2'd2) begin
            miscompares++;
            $display("FAIL single_carry: valid=%b sum=%h cout=%b id=%0d expected 1/15/1/2",
                     rsp_valid, rsp_sum, rsp_cout, rsp_id);
        end
        tick();
        req_valid = '0;
        sample();
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 8'h46 || rsp_cout !== 1'b0 || rsp_id !== 2'd2) begin
            miscompares++;
            $display("FAIL single_nocarry: valid=%b sum=%h cout=%b id=%0d expected 1/46/0/2",
                     rsp_valid, rsp_sum, rsp_cout, rsp_id);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0]         exp_sum;
        logic [NUM_REQ-1:0] exp_rdy;
        tick();
        rst       = 1'b1;
        req_valid = '0;
        tick();
        rst       = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 8'(i), 8'(i));
        for (int k = 0; k < 7; k++) begin
            sample();
            exp_rdy = '0;
            exp_rdy[k % NUM_REQ] = 1'b1;
            vectors++;
            if (req_ready !== exp_rdy) begin
                miscompares++;
                $display("FAIL rr_grant_%0d: req_ready=%b expected %b", k, req_ready, exp_rdy);
            end
            if (k >= 1) begin
                exp_sum = 8'(((k - 1) % NUM_REQ) * 2);
                vectors++;
                if (rsp_valid !== 1'b1 || rsp_id !== ID_W'((k - 1) % NUM_REQ) || rsp_sum !== exp_sum) begin
                    miscompares++;
                    $display("FAIL rr_rsp_%0d: valid=%b id=%0d sum=%h expected 1/%0d/%h",
                             k, rsp_valid, rsp_id, rsp_sum, (k - 1) % NUM_REQ, exp_sum);
                end
            end
            tick();
        end
        req_valid = '0;
        sample();
    endtask

    task automatic test_backpressure();
        tick();
        rsp_ready = 1'b0;
        set_req(1, 1'b1, 8'h81, 8'h80);
        set_req(3, 1'b1, 8'h83, 8'h80);
        sample();
        vectors++;
        if (req_ready !== 4'b1000) begin
            miscompares++;
            $display("FAIL bp_first_grant: req_ready=%b expected 1000", req_ready);
        end
        tick();
        req_valid[3] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            sample();
            vectors++;
            if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_sum !== 8'h03 || rsp_cout !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_hold_%0d: ready=%b valid=%b id=%0d sum=%h cout=%b expected 0000/1/3/03/1",
                         k, req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout);
            end
            tick();
        end
        rsp_ready = 1'b1;
        sample();
        vectors++;
        if (req_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL bp_release_grant: req_ready=%b expected 0010", req_ready);
        end
        tick();
        req_valid = '0;
        sample();
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 8'h01 || rsp_cout !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_next_rsp: valid=%b id=%0d sum=%h cout=%b expected 1/1/01/1",
                     rsp_valid, rsp_id, rsp_sum, rsp_cout);
        end
    endtask

    task automatic test_wrap();
        tick();
        set_req(3, 1'b1, 8'hFF, 8'h01);
        sample();
        vectors++;
        if (req_ready !== 4'b1000) begin
            miscompares++;
            $display("FAIL wrap_grant3: req_ready=%b expected 1000", req_ready);
        end
        tick();
        req_valid[3] = 1'b0;
        set_req(0, 1'b1, 8'h00, 8'h00);
        sample();
        vectors++;
        if (req_ready !== 4'b0001 || rsp_id !== 2'd3 || rsp_sum !== 8'h00 || rsp_cout !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_grant0: ready=%b id=%0d sum=%h cout=%b expected 0001/3/00/1",
                     req_ready, rsp_id, rsp_sum, rsp_cout);
        end
        tick();
        set_req(1, 1'b1, 8'h7F, 8'h01);
        sample();
        vectors++;
        if (req_ready !== 4'b0010 || rsp_id !== 2'd0 || rsp_sum !== 8'h00 || rsp_cout !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_after0: ready=%b id=%0d sum=%h cout=%b expected 0010/0/00/0",
                     req_ready, rsp_id, rsp_sum, rsp_cout);
        end
        tick();
        req_valid = '0;
        sample();
        vectors++;
        if (rsp_id !== 2'd1 || rsp_sum !== 8'h80 || rsp_cout !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_rsp1: id=%0d sum=%h cout=%b expected 1/80/0", rsp_id, rsp_sum, rsp_cout);
        end
    endtask

    task automatic test_reset_mid();
        tick();
        rsp_ready = 1'b0;
        set_req(2, 1'b1, 8'hC0, 8'hC0);
        sample();
        tick();
        req_valid = '0;
        sample();
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 8'h80 || rsp_cout !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_loaded: valid=%b id=%0d sum=%h cout=%b expected 1/2/80/1",
                     rsp_valid, rsp_id, rsp_sum, rsp_cout);
        end
        tick();
        rst = 1'b1;
        sample();
        tick();
        rst = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 8'h10, 8'(i));
        sample();
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL mid_after_rst: valid=%b ready=%b expected 0/0001", rsp_valid, req_ready);
        end
        tick();
        req_valid = '0;
        rsp_ready = 1'b1;
        sample();
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 8'h10) begin
            miscompares++;
            $display("FAIL mid_rsp0: valid=%b id=%0d sum=%h expected 1/0/10", rsp_valid, rsp_id, rsp_sum);
        end
        tick();
        sample();
        vectors++;
        if (m_q.size() != 0 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drain: pending=%0d valid=%b expected 0/0", m_q.size(), rsp_valid);
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_ain   = '0;
        req_bin   = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_single_carry();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/zilla_adder_arbiter.md
Name: zilla_adder_arbiter

Overview:
- Shares one 8-bit carry-lookahead adder (`cla_adder_8bit`: `ain`, `bin`, `sum`; no carry-in or carry-out) between NUM_REQ requesters.
- Arbitration is round-robin over valid/ready handshakes, with a single registered response slot.
- Each response is tagged with the requester ID and a carry-out that the block derives itself.
- Sits between the fabric's small ALU clients and the shared adder, so only one adder instance is needed per tile.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester ID; must equal clog2(NUM_REQ), minimum 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester operation request.
- req_ain  input  NUM_REQ*8  operand A; requester i uses bits [8i+7:8i].
- req_bin  input  NUM_REQ*8  operand B; same packing as req_ain.
- req_ready  output  NUM_REQ  one-hot grant; requester i is accepted when req_valid[i] and req_ready[i] are both 1.
- rsp_valid  output  1  response slot holds a result.
- rsp_ready  input  1  consumer accepts the response.
- rsp_sum  output  8  (A+B) mod 256.
- rsp_cout  output  1  carry out of bit 7.
- rsp_id  output  ID_W  index of the requester that produced the response.

Behaviour:
- Reset (synchronous, active-high, clk rising edge):
  - rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0.
  - Priority pointer ptr=0.
  - req_ready=0 for the cycle rst is high.
- Slot state is a two-state FSM:
  - EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
  - can_accept = EMPTY, or (FULL and rsp_ready). Pass-through on the same cycle is supported.
- Arbitration (combinational):
  - When can_accept and any req_valid is set, grant the first valid requester scanning ptr, ptr+1, …, wrapping modulo NUM_REQ.
  - req_ready is one-hot on the winner and 0 elsewhere.
  - When can_accept is 0, req_ready is all 0.
  - req_ready may depend combinationally on req_valid and rsp_ready. Requesters must not make req_valid depend on req_ready.
- Datapath:
  - The winner's operands are muxed into the single adder instance.
  - cout = (a7 & b7) | ((a7 | b7) & ~s7), where s7 is adder sum bit 7.
- Accept edge (a grant occurred):
  - rsp_sum, rsp_cout and rsp_id load the winner's values; FSM goes to FULL.
  - ptr becomes winner+1, wrapping from NUM_REQ-1 to 0.
- Latency: exactly 1 cycle from accept to rsp_valid=1.
- Throughput: 1 result per cycle while rsp_ready=1.
- Consume without a new accept (FULL, rsp_ready=1, no req_valid): FSM goes to EMPTY; rsp_sum, rsp_cout and rsp_id hold their last values.
- Backpressure (FULL, rsp_ready=0):
  - rsp_* hold stable and req_ready is all 0.
  - ptr is unchanged and no request is dropped.
- Starvation bound: a requester holding req_valid continuously is granted within NUM_REQ accepts.
- A requester deasserting req_valid before it is granted is legal; nothing is recorded.
- Reset mid-operation: a pending response is discarded (rsp_valid=0 on the next cycle) and ptr returns to 0.
- Simultaneous rst and handshake: rst wins and nothing is loaded.
- Any NUM_REQ not a power of 2 (e.g. 3): ptr wraps at NUM_REQ-1. Ports for IDs ≥ NUM_REQ do not exist.

Decomposition:
- Shared package (zilla_pkg) holds:
  - ADDER_W=8.
  - The slot-state encoding, EMPTY=1'b0 and FULL=1'b1.
  - A function rr_pick(valid, ptr) returning winner index and found flag, reusable by other fabric arbiters.
- One natural sub-module, zilla_rr_arbiter: pointer register plus one-hot grant logic. It is parameterised by NUM_REQ and driven by can_accept.
- The top level instantiates zilla_rr_arbiter and one `cla_adder_8bit`.

Test Plan:
- Reset check:
  - Stimulus: rst=1 for 2 cycles with all req_valid=1.
  - Required: req_ready=0, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0 throughout; after release, first grant goes to requester 0.
- Single requester with carry:
  - Stimulus: req 2 with A=0xF0, B=0x25, rsp_ready=1.
  - Required: one cycle later rsp_valid=1, rsp_sum=0x15, rsp_cout=1, rsp_id=2. Then with A=0x12, B=0x34: rsp_sum=0x46, rsp_cout=0.
- Round-robin fairness:
  - Stimulus: all 4 requesters valid continuously, rsp_ready=1, operands A=i, B=i.
  - Required: rsp_id sequence 0,1,2,3,0,1 with sums 0,2,4,6,0,2; one response per cycle.
- Backpressure:
  - Stimulus: rsp_ready=0 for 5 cycles with req 1 and req 3 valid after one response has loaded.
  - Required: rsp_* stable and req_ready=0 for all 5 cycles. On rsp_ready=1, the next id is the one after the held id in round-robin order, and no operation is lost.
- Pointer wrap / skip:
  - Stimulus: only requester 3 valid, then only requester 0 valid.
  - Required: grants 3 then 0; ptr after grant 3 wraps to 0.
- Reset mid-operation:
  - Stimulus: assert rst while rsp_valid=1 and rsp_ready=0.
  - Required: rsp_valid=0 on the next cycle; after release, requester 0 has priority.
